reset_sequencer: RTL and testbench

Multi-channel reset synchronizer and release sequencer. Each output asserts asynchronously on `w_new_reset`. The outputs de-assert synchronously to `clk` in fixed order (channel 0 first), with a programmable stretch before the first release and a programmable step between releases. It sits at the top of each clock domain and drives that domain's ordered subsystem resets: interconnect, then cores, then peripherals. A synchronous software reset request re-runs the sequence.

---
 rtl/reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Multi-channel reset synchronizer and ordered release sequencer for one
// clock domain. All channel resets assert asynchronously when w_new_reset
// goes low. After w_new_reset rises, the resets release synchronously to
// clk in channel order (channel 0 first). A programmable stretch comes
// before the first release and a programmable step separates each release
// after that. A synchronous software request re-runs the release sequence.
//
// Parameters:
//   P_NUM_CH  : number of reset channels (1..16)
//   P_NUM_FF  : synchronizer depth (>= 2)
//   P_STRETCH : cycles from synchronized release to channel 0 release (>= 1)
//   P_STEP    : cycles between consecutive channel releases (>= 1)
//   P_OUT_POL : per-channel asserted level (0 = active-low, 1 = active-high)
//
// Ports:
//   clk         : destination-domain clock
//   w_new_reset : asynchronous active-low reset
//   i_sw_reset  : synchronous level-sensitive software reset request
//   o_rst       : per-channel resets, registered, polarity from P_OUT_POL
//   o_rst_done  : registered, high once every channel is released
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int                  P_NUM_CH  = 4,
    parameter int                  P_NUM_FF  = 2,
    parameter int                  P_STRETCH = 16,
    parameter int                  P_STEP    = 8,
    parameter logic [P_NUM_CH-1:0] P_OUT_POL = {P_NUM_CH{1'b0}}
) (
    input  logic                clk,
    input  logic                w_new_reset,
    input  logic                i_sw_reset,
    output logic [P_NUM_CH-1:0] o_rst,
    output logic                o_rst_done
);

    localparam int MAX_CNT = (P_STRETCH > P_STEP) ? P_STRETCH : P_STEP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1;

    // The counter holds the number of cycles already spent in the current
    // wait, so a wait ends when it has counted one less than its length.
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(P_STRETCH - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(P_STEP - 1);
    localparam logic [IDX_W-1:0] LAST_CH      = IDX_W'(P_NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_DONE
    } state_t;

    logic [P_NUM_FF-1:0] sync_q;
    logic                sync_n;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [P_NUM_CH-1:0] rst_q, rst_d;
    logic                done_q, done_d;

    // Reset synchronizer: cleared asynchronously, then fills with ones so
    // that the release of w_new_reset reaches the sequencer only after
    // P_NUM_FF clean clk edges. Software reset deliberately leaves it alone.
    always_ff @(posedge clk or negedge w_new_reset) begin
        if (!w_new_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[P_NUM_FF-2:0], 1'b1};
        end
    end

    assign sync_n = sync_q[P_NUM_FF-1];

    // Sequencer registers. The channel outputs and the done flag are kept
    // in flops here so nothing combinational ever reaches o_rst.
    always_ff @(posedge clk or negedge w_new_reset) begin
        if (!w_new_reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= P_OUT_POL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. A software request outside HOLD re-asserts every
    // channel and parks the sequencer at the start of the stretch; while
    // the request stays high the counter is pinned at zero, so the stretch
    // is measured from the last edge that saw the request.
    // The edge that first sees sync_n already counts as one stretch cycle,
    // which is why HOLD either releases channel 0 directly (stretch of one)
    // or enters STRETCH with one cycle already counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;

        if ((state_q != ST_HOLD) && i_sw_reset) begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = P_OUT_POL;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (sync_n) begin
                        if (P_STRETCH == 1) begin
                            state_d  = ST_RELEASE;
                            cnt_d    = '0;
                            idx_d    = '0;
                            rst_d[0] = ~P_OUT_POL[0];
                        end else begin
                            state_d = ST_STRETCH;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_STRETCH: begin
                    if (cnt_q == STRETCH_LAST) begin
                        state_d  = ST_RELEASE;
                        cnt_d    = '0;
                        idx_d    = '0;
                        rst_d[0] = ~P_OUT_POL[0];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (idx_q == LAST_CH) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else if (cnt_q == STEP_LAST) begin
                        idx_d        = idx_q + IDX_W'(1);
                        cnt_d        = '0;
                        rst_d[idx_d] = ~P_OUT_POL[idx_d];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rst      = rst_q;
    assign o_rst_done = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//
// Drives four reset_sequencer instances with different parameter sets from
// one shared reset and software request, and compares every instance each
// cycle against an edge-counting model of the release schedule.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int NCH [4] = '{4, 4, 1, 3};
    localparam int NFF [4] = '{2, 2, 3, 2};
    localparam int STR [4] = '{16, 16, 1, 3};
    localparam int STP [4] = '{8, 8, 8, 2};
    localparam logic [3:0] POL [4] = '{4'b0000, 4'b1010, 4'b0000, 4'b0100};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_reset;
    logic [3:0] rst0;
    logic [3:0] rst1;
    logic [0:0] rst2;
    logic [2:0] rst3;
    logic       done0, done1, done2, done3;

    int e_cnt [4];
    int base  [4];
    int scen;
    int sw_s;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.P_NUM_CH(4), .P_NUM_FF(2), .P_STRETCH(16), .P_STEP(8),
                      .P_OUT_POL(4'b0000)) u_dut0 (
        .clk(clk), .w_new_reset(rst_n), .i_sw_reset(sw_reset),
        .o_rst(rst0), .o_rst_done(done0));

    reset_sequencer #(.P_NUM_CH(4), .P_NUM_FF(2), .P_STRETCH(16), .P_STEP(8),
                      .P_OUT_POL(4'b1010)) u_dut1 (
        .clk(clk), .w_new_reset(rst_n), .i_sw_reset(sw_reset),
        .o_rst(rst1), .o_rst_done(done1));

    reset_sequencer #(.P_NUM_CH(1), .P_NUM_FF(3), .P_STRETCH(1), .P_STEP(8),
                      .P_OUT_POL(1'b0)) u_dut2 (
        .clk(clk), .w_new_reset(rst_n), .i_sw_reset(sw_reset),
        .o_rst(rst2), .o_rst_done(done2));

    reset_sequencer #(.P_NUM_CH(3), .P_NUM_FF(2), .P_STRETCH(3), .P_STEP(2),
                      .P_OUT_POL(3'b100)) u_dut3 (
        .clk(clk), .w_new_reset(rst_n), .i_sw_reset(sw_reset),
        .o_rst(rst3), .o_rst_done(done3));

    // Reference model: count clock edges since reset released. Channel k of
    // an instance is released once the count reaches base + k*STEP, and the
    // done flag one edge after the last channel. A software request that
    // lands after the hold phase (more than NFF edges already seen) pushes
    // base to STRETCH edges past the edge that sampled it.
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 4; d++) begin
            if (!rst_n) begin
                e_cnt[d] <= 0;
                base[d]  <= NFF[d] + STR[d];
            end else begin
                e_cnt[d] <= e_cnt[d] + 1;
                if (sw_reset && (e_cnt[d] > NFF[d])) begin
                    base[d] <= e_cnt[d] + 1 + STR[d];
                end
            end
        end
    end

    function automatic logic [3:0] exp_rst(int d);
        logic [3:0] r;
        r = 4'b0000;
        for (int k = 0; k < NCH[d]; k++) begin
            r[k] = POL[d][k] ^ (e_cnt[d] >= base[d] + k * STP[d]);
        end
        return r;
    endfunction

    function automatic logic exp_done(int d);
        return e_cnt[d] >= base[d] + (NCH[d] - 1) * STP[d] + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act,
                               input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: actual %b required %b",
                     name, e_cnt[0], act, req);
        end
    endtask

    // Compare process: on every falling clock edge, and just after any
    // reset fall (without waiting for a clock), check all instances against
    // the model, plus the hand-computed schedule points of the directed runs.
    always @(negedge clk or negedge rst_n) begin
        logic [3:0] act_rst [4];
        logic       act_done [4];
        #1;
        act_rst[0] = rst0;
        act_rst[1] = rst1;
        act_rst[2] = {3'b000, rst2};
        act_rst[3] = {1'b0, rst3};
        act_done[0] = done0;
        act_done[1] = done1;
        act_done[2] = done2;
        act_done[3] = done3;
        for (int d = 0; d < 4; d++) begin
            checkOutput($sformatf("model_rst%0d", d), act_rst[d], exp_rst(d));
            checkOutput($sformatf("model_done%0d", d), {3'b000, act_done[d]},
                        {3'b000, exp_done(d)});
        end
        if (!rst_n) begin
            checkOutput("async_rst0", rst0, 4'b0000);
            checkOutput("async_rst1", rst1, 4'b1010);
            checkOutput("async_done0", {3'b000, done0}, 4'b0000);
        end else if (scen == 1 || scen == 2 || scen == 4) begin
            case (e_cnt[0])
                3: checkOutput("lit_rst2_e3", {3'b000, rst2}, 4'b0000);
                4: begin
                    checkOutput("lit_rst2_e4", {3'b000, rst2}, 4'b0001);
                    checkOutput("lit_done2_e4", {3'b000, done2}, 4'b0000);
                end
                5: checkOutput("lit_done2_e5", {3'b000, done2}, 4'b0001);
                17: begin
                    checkOutput("lit_rst0_e17", rst0, 4'b0000);
                    checkOutput("lit_rst1_e17", rst1, 4'b1010);
                end
                18: begin
                    checkOutput("lit_rst0_e18", rst0, 4'b0001);
                    checkOutput("lit_rst1_e18", rst1, 4'b1011);
                end
                26: begin
                    checkOutput("lit_rst0_e26", rst0, 4'b0011);
                    checkOutput("lit_rst1_e26", rst1, 4'b1001);
                end
                34: begin
                    checkOutput("lit_rst0_e34", rst0, 4'b0111);
                    checkOutput("lit_rst1_e34", rst1, 4'b1101);
                end
                42: begin
                    checkOutput("lit_rst0_e42", rst0, 4'b1111);
                    checkOutput("lit_rst1_e42", rst1, 4'b0101);
                    checkOutput("lit_done0_e42", {3'b000, done0}, 4'b0000);
                end
                43: checkOutput("lit_done0_e43", {3'b000, done0}, 4'b0001);
                default: begin
                end
            endcase
        end else if (scen == 3) begin
            case (e_cnt[0] - sw_s)
                0: begin
                    checkOutput("lit_sw_rst0_s", rst0, 4'b0000);
                    checkOutput("lit_sw_done0_s", {3'b000, done0}, 4'b0000);
                end
                17: checkOutput("lit_sw_rst0_s17", rst0, 4'b0000);
                18: checkOutput("lit_sw_rst0_s18", rst0, 4'b0001);
                42: checkOutput("lit_sw_done0_s42", {3'b000, done0}, 4'b0000);
                43: checkOutput("lit_sw_done0_s43", {3'b000, done0}, 4'b0001);
                default: begin
                end
            endcase
        end
    end

    // Short reset pulse placed between clock edges, called right after a
    // rising edge; it ends before the next rising edge.
    task automatic applyStimulus();
        #7 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // Directed runs first, then a randomized stretch of software requests
    // and short reset pulses.
    initial begin
        rst_n    = 1'b1;
        sw_reset = 1'b0;
        scen     = 1;
        sw_s     = 0;
        #1 rst_n = 1'b0;
        #21 rst_n = 1'b1;
        $display("[TB] power-up sequence");
        repeat (50) @(posedge clk);

        $display("[TB] reset pulse mid-release");
        scen = 2;
        applyStimulus();
        repeat (26) @(posedge clk);
        applyStimulus();
        repeat (50) @(posedge clk);

        $display("[TB] software reset from done");
        #2;
        scen     = 3;
        sw_s     = e_cnt[0] + 1;
        sw_reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 sw_reset = 1'b0;
        repeat (50) @(posedge clk);

        $display("[TB] software reset held during hold");
        scen = 4;
        applyStimulus();
        sw_reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 sw_reset = 1'b0;
        repeat (47) @(posedge clk);

        $display("[TB] randomized requests");
        scen = 5;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #2;
            if (sw_reset) begin
                sw_reset = ($urandom_range(0, 2) != 0);
            end else begin
                sw_reset = ($urandom_range(0, 59) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                #5 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        sw_reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
